// File: rtl/anim_pkg.sv
// Shared definitions for the LED animation playback controller:
// state encoding, datapath widths and the frame-step helper.
package anim_pkg;

  localparam int FM_W  = 5;
  localparam int DIV_W = 27;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_STEP  = 2'd3;

  typedef logic [1:0] state_t;

  typedef struct packed {
    logic dir;
    logic step;
    logic play;
  } btn_ev_t;

  // One frame forward or backward, wrapping between 0 and last.
  function automatic logic [FM_W-1:0] fm_advance(
    input logic [FM_W-1:0] fm,
    input logic            rev,
    input logic [FM_W-1:0] last
  );
    if (rev) begin
      return (fm == '0) ? last : fm - 1'b1;
    end
    return (fm == last) ? '0 : fm + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // A disagreeing sample run must last DEB_CYC cycles; any agreeing sample restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/anim_playback_ctrl.sv
// Play/pause/step/stop/reverse controller for the LED animation: debounced
// buttons drive a small FSM that paces frame advances from the speed switches.
module anim_playback_ctrl
  import anim_pkg::*;
#(
  parameter int unsigned FRAMES  = 32,
  parameter int unsigned PERIOD0 = 50_000_000,
  parameter int unsigned PERIOD1 = 25_000_000,
  parameter int unsigned PERIOD2 = 12_500_000,
  parameter int unsigned PERIOD3 = 6_250_000,
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_btn_play,
  input  logic            i_btn_step,
  input  logic            i_btn_dir,
  input  logic            i_btn_stop,
  input  logic [1:0]      i_sw_state,
  output logic [FM_W-1:0] o_fm_no,
  output logic            o_fc,
  output logic            o_playing,
  output logic            o_dir
);

  localparam logic [FM_W-1:0]  FM_LAST = FM_W'(FRAMES - 1);
  localparam logic [DIV_W-1:0] P0_LAST = DIV_W'(PERIOD0 - 1);
  localparam logic [DIV_W-1:0] P1_LAST = DIV_W'(PERIOD1 - 1);
  localparam logic [DIV_W-1:0] P2_LAST = DIV_W'(PERIOD2 - 1);
  localparam logic [DIV_W-1:0] P3_LAST = DIV_W'(PERIOD3 - 1);

  logic [2:0]       w_raw;
  logic [2:0]       w_rise;
  btn_ev_t          w_ev;
  logic [DIV_W-1:0] w_period_last;
  logic             w_speed_chg;
  logic             w_div_done;
  logic             w_adv;
  state_t           w_state_next;
  logic [DIV_W-1:0] w_div_next;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_sw;
  logic [FM_W-1:0]  r_fm_no;
  logic             r_fc;
  logic             r_dir;

  assign w_raw = {i_btn_dir, i_btn_step, i_btn_play};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      btn_debounce #(
        .DEB_CYC (DEB_CYC)
      ) u_deb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (w_raw[gi]),
        .o_rise (w_rise[gi])
      );
    end
  endgenerate

  assign w_ev = btn_ev_t'(w_rise);

  always_comb begin
    w_period_last = P0_LAST;
    case (r_sw)
      2'd1:    w_period_last = P1_LAST;
      2'd2:    w_period_last = P2_LAST;
      2'd3:    w_period_last = P3_LAST;
      default: w_period_last = P0_LAST;
    endcase
  end

  // A switch change restarts the period and suppresses the advance that cycle.
  assign w_speed_chg = (i_sw_state != r_sw);
  assign w_div_done  = (r_div == w_period_last);
  assign w_adv       = !i_btn_stop &&
                       (((r_state == ST_PLAY) && !w_speed_chg && w_div_done) ||
                        (r_state == ST_STEP));

  // Stop beats play beats step; a step that loses is simply dropped.
  always_comb begin
    w_state_next = r_state;
    if (i_btn_stop) begin
      w_state_next = ST_STOP;
    end else begin
      case (r_state)
        ST_STOP: begin
          if (w_ev.play)      w_state_next = ST_PLAY;
          else if (w_ev.step) w_state_next = ST_STEP;
        end
        ST_PLAY: begin
          if (w_ev.play)      w_state_next = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (w_ev.play)      w_state_next = ST_PLAY;
          else if (w_ev.step) w_state_next = ST_STEP;
        end
        ST_STEP:              w_state_next = ST_PAUSE;
        default:              w_state_next = ST_STOP;
      endcase
    end
  end

  always_comb begin
    w_div_next = r_div;
    if (i_btn_stop || (r_state == ST_STOP) || w_speed_chg) begin
      w_div_next = '0;
    end else if (r_state == ST_PLAY) begin
      w_div_next = w_div_done ? '0 : r_div + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_STOP;
      r_div   <= '0;
      r_sw    <= '0;
      r_fm_no <= '0;
      r_fc    <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_sw    <= i_sw_state;
      r_fc    <= w_adv;
      r_dir   <= r_dir ^ w_ev.dir;
      if (i_btn_stop) begin
        r_fm_no <= '0;
      end else if (w_adv) begin
        r_fm_no <= fm_advance(r_fm_no, r_dir, FM_LAST);
      end
    end
  end

  assign o_fm_no   = r_fm_no;
  assign o_fc      = r_fc;
  assign o_playing = (r_state == ST_PLAY);
  assign o_dir     = r_dir;

endmodule

// File: tb/tb_anim_playback_ctrl.sv
// Randomised bench for anim_playback_ctrl against a cycle-level behavioural
// model built from the playback rules (press -> event delay, modulo frames).
module tb_anim_playback_ctrl;

  localparam int FRAMES = 5;
  localparam int MAXC   = 4096;
  // Clean press started in cycle k is accepted as an event seen at edge k+EV_LAT.
  localparam int EV_LAT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_play = 1'b0, b_step = 1'b0, b_dir = 1'b0, b_stop = 1'b0;
  logic [1:0] sw = 2'd0;
  logic [4:0] fm_no;
  logic       fc, playing, dir;

  always #5 clk = ~clk;

  anim_playback_ctrl #(
    .FRAMES  (FRAMES),
    .PERIOD0 (8),
    .PERIOD1 (4),
    .PERIOD2 (2),
    .PERIOD3 (1),
    .DEB_CYC (3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_play (b_play),
    .i_btn_step (b_step),
    .i_btn_dir  (b_dir),
    .i_btn_stop (b_stop),
    .i_sw_state (sw),
    .o_fm_no    (fm_no),
    .o_fc       (fc),
    .o_playing  (playing),
    .o_dir      (dir)
  );

  typedef enum int {M_STOP, M_PLAY, M_PAUSE, M_STEP} mstate_e;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc     = 0;
  mstate_e m_state;
  int      m_elapsed, m_fm, m_sw_prev;
  bit      m_fc, m_dir;
  bit      ev_sched [3][MAXC];
  int      rel [3];
  int      next_ok [3];
  bit      bounce = 1'b0;
  string   bname [3] = '{"play", "step", "dir"};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int period(input int s);
    case (s)
      0:       return 8;
      1:       return 4;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_state   = M_STOP;
    m_elapsed = 0;
    m_fm      = 0;
    m_fc      = 1'b0;
    m_dir     = 1'b0;
    m_sw_prev = 0;
  endtask

  // Expected effect of the coming clock edge, given the inputs now applied.
  task automatic model_step();
    bit      stp, pe, se, de, chg, adv;
    mstate_e nxt;
    stp = b_stop;
    pe  = ev_sched[0][cyc+1];
    se  = ev_sched[1][cyc+1];
    de  = ev_sched[2][cyc+1];
    chg = (int'(sw) != m_sw_prev);
    adv = !stp && ((m_state == M_PLAY && !chg && m_elapsed == period(int'(sw)) - 1) ||
                   m_state == M_STEP);
    nxt = m_state;
    if (stp) nxt = M_STOP;
    else if (m_state == M_STEP) nxt = M_PAUSE;
    else if (pe && m_state == M_PLAY) nxt = M_PAUSE;
    else if (pe) nxt = M_PLAY;
    else if (se && m_state != M_PLAY) nxt = M_STEP;
    if (stp || m_state == M_STOP || chg) m_elapsed = 0;
    else if (m_state == M_PLAY) m_elapsed = adv ? 0 : m_elapsed + 1;
    if (stp) m_fm = 0;
    else if (adv) m_fm = m_dir ? (m_fm + FRAMES - 1) % FRAMES : (m_fm + 1) % FRAMES;
    m_fc      = adv;
    m_dir     = m_dir ^ de;
    m_sw_prev = int'(sw);
    m_state   = nxt;
  endtask

  task automatic step_cycle();
    b_play = (cyc < rel[0]) || bounce;
    b_step = (cyc < rel[1]);
    b_dir  = (cyc < rel[2]);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("fm_no",   32'(fm_no),   32'(m_fm));
    chk("fc",      32'(fc),      32'(m_fc));
    chk("playing", 32'(playing), 32'(m_state == M_PLAY));
    chk("dir",     32'(dir),     32'(m_dir));
  endtask

  task automatic idle(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic press(input int b, input int len);
    rel[b]                 = cyc + len;
    ev_sched[b][cyc+EV_LAT] = 1'b1;
    next_ok[b]             = cyc + len + 8;
    $display("[TB] cyc=%0d press %s len=%0d fm=%0d sw=%0d", cyc, bname[b], len, fm_no, sw);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, stop_left;
    for (int b = 0; b < 3; b++) begin
      rel[b] = 0;
      next_ok[b] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fm",      32'(fm_no),   32'd0);
    chk("rst_fc",      32'(fc),      32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_dir",     32'(dir),     32'd0);
    rst = 1'b0;
    $display("[TB] cyc=%0d reset released", cyc);

    // Play from reset: first advance after one full PERIOD0 in PLAY.
    k = cyc;
    press(0, 6);
    idle(14);
    chk("first_adv_fm", 32'(fm_no), 32'd1);
    chk("first_adv_fc", 32'(fc),    32'd1);
    idle(34);
    press(0, 6); idle(50);
    chk("pause_playing", 32'(playing), 32'd0);
    press(0, 6); idle(30);
    press(2, 4); idle(10);
    press(1, 4); idle(10);
    press(1, 3); idle(10);
    $display("[TB] cyc=%0d directed part done fm=%0d dir=%0d", cyc, fm_no, dir);

    // Random mix of presses, stop pulses and speed changes.
    stop_left = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 3; b++) begin
        int odds;
        odds = (b == 0) ? 40 : (b == 1) ? 15 : 30;
        if (cyc >= next_ok[b] && $urandom_range(0, odds - 1) == 0)
          press(b, int'($urandom_range(3, 7)));
      end
      if (stop_left > 0) begin
        b_stop = 1'b1;
        stop_left--;
      end else begin
        b_stop = 1'b0;
        if ($urandom_range(0, 199) == 0) begin
          stop_left = int'($urandom_range(1, 3));
          $display("[TB] cyc=%0d stop for %0d cycles", cyc, stop_left);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        sw = 2'($urandom_range(0, 3));
        $display("[TB] cyc=%0d speed code %0d", cyc, sw);
      end
      step_cycle();
    end
    b_stop = 1'b0;
    idle(20);

    // Step event and stop in the same cycle: stop wins, no advance.
    k = cyc;
    press(1, 4);
    idle(EV_LAT - 1);
    b_stop = 1'b1;
    step_cycle();
    b_stop = 1'b0;
    $display("[TB] cyc=%0d step+stop collision", cyc);
    chk("coll_fm",      32'(fm_no),   32'd0);
    chk("coll_fc",      32'(fc),      32'd0);
    chk("coll_playing", 32'(playing), 32'd0);
    idle(15);

    // Fastest speed in PLAY, then asynchronous reset in mid-cycle.
    sw = 2'd3;
    press(0, 5);
    idle(20);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] cyc=%0d async reset during play", cyc);
    chk("arst_fm",      32'(fm_no),   32'd0);
    chk("arst_fc",      32'(fc),      32'd0);
    chk("arst_playing", 32'(playing), 32'd0);
    chk("arst_dir",     32'(dir),     32'd0);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    model_reset();
    idle(5);

    // Bounce on play while playing must not be accepted.
    sw = 2'd1;
    press(0, 6);
    idle(20);
    $display("[TB] cyc=%0d bounce on play", cyc);
    for (int i = 0; i < 5; i++) begin
      bounce = 1'b1; idle(2);
      bounce = 1'b0; idle(2);
    end
    idle(10);
    chk("bounce_playing", 32'(playing), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
